instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Program-sequencing stage directly upstream of the control decoder. Holds the PC, drives
//  instruction-memory address, forwards the 9-bit instruction to the decoder, and consumes the
//  decoder's stall/jen/jptr/Done outputs to choose the next PC. Jptr indexes a loadable
//  jump-target LUT (jump_lut) of absolute PCs. Also keeps run-time cycle/instruction counters.
// PARAMETERS
//  PC_W      10   PC / imem address width
//  IW         9   instruction width
//  LUT_AW     6   jump LUT address width (2**LUT_AW entries); uses jptr[LUT_AW-1:0]
//  RESET_PC   0   PC loaded at reset and at every start
//  CNT_W     16   perf counter width
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        1-cycle pulse; begins a run from IDLE or HALT
//  imem_data  in   IW       instruction at imem_addr (combinational ROM read)
//  imem_addr  out  PC_W     = PC
//  mach_code  out  IW       instruction to decoder
//  stall      in   1        decoder: current instr is 2-cycle
//  jen        in   1        decoder: branch instruction
//  jptr       in   8        decoder: jump LUT index
//  br_cond    in   1        ALU flag; branch taken iff jen & br_cond
//  done_in    in   1        decoder Done
//  lut_we     in   1        LUT write strobe (honoured in IDLE/HALT only)
//  lut_waddr  in   LUT_AW   LUT write index
//  lut_wdata  in   PC_W     LUT write target
//  busy       out  1        1 in RUN
//  done       out  1        sticky program-complete flag
//  instr_cnt  out  CNT_W    instructions retired this run
//  cycle_cnt  out  CNT_W    RUN cycles this run
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, PC=RESET_PC, phase=0, busy=0, done=0, counters=0,
//   all LUT entries=0. Takes effect immediately, including mid-run or mid-stall.
//  States: IDLE, RUN, HALT. IDLE/HALT --start--> RUN (PC=RESET_PC, counters=0, done=0, phase=0).
//   RUN --retire with done_in--> HALT (done=1). start in RUN is ignored.
//  mach_code = imem_data in RUN; 9'h0FF (halt encoding, no reg write) in IDLE/HALT.
//  RUN next-PC priority, evaluated each cycle:
//   1 done_in            : PC held, retire, -> HALT
//   2 stall & phase==0   : PC held, phase<=1, no retire (instr occupies 2 cycles)
//   3 jen & br_cond      : PC<=LUT[jptr[LUT_AW-1:0]], phase<=0, retire
//   4 otherwise          : PC<=PC+1 mod 2**PC_W (max wraps to 0), phase<=0, retire
//   A stalled branch therefore resolves in its second cycle; jen with br_cond=0 falls to 4.
//  Latency: combinational imem->mach_code; one PC update per retire; zero bubbles on jump.
//  Counters: cycle_cnt +1 every RUN cycle; instr_cnt +1 per retire (incl. Done instr);
//   both saturate at all-ones; frozen in HALT; cleared by start or reset.
//  LUT: write at clk when lut_we & state!=RUN; writes during RUN dropped. Write and jump
//   read of same entry can't collide (RUN excludes writes). Read is combinational.
//  start and lut_we in same IDLE cycle: both take effect.
// STRUCTURE
//  Shared package: fetch_state_t enum {IDLE,RUN,HALT}; HALT_INSTR=9'h0FF; IW, PC_W defaults.
//  Sub-module jump_lut: 2**LUT_AW x PC_W register file, 1 sync write, 1 comb read, async clear.
//  Top: FSM, PC/phase regs, next-PC mux, saturating counters.
// TESTING
//  Reset then start; ROM 0..3 plain ALU ops, 4=9'h0FF -> PC 0,1,2,3,4, HALT, done=1,
//   instr_cnt=5, cycle_cnt=5, mach_code=9'h0FF afterwards.
//  Stall at PC 2 -> PC holds 2 cycles (2,2,3), cycle_cnt exceeds instr_cnt by 1.
//  LUT[5]=0x20 in IDLE; branch jptr=5 at PC 3, br_cond=1 -> PC 0x20 next; br_cond=0 -> PC 4.
//  lut_we during RUN with wdata=0x3FF -> entry unchanged, later jump uses old value.
//  Straight-line from PC 0x3FF -> next PC 0x000; CNT_W=4 run of 20 instrs -> instr_cnt=15.
//  rst_n low mid-stall in RUN -> immediately IDLE, PC=0, counters=0, LUT=0, busy=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int DEF_PC_W = 10;
    localparam int DEF_IW   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Presented to the decoder whenever the stage is not running: halts, writes nothing.
    localparam logic [DEF_IW-1:0] HALT_INSTR = 9'h0FF;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_jump_lut.sv
`default_nettype none
// ============================================================================
//  Module      : jump_lut
//  Description : Jump-target register file, one sync write, one comb read.
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_lut #(
    parameter int AW = 6,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : PC sequencer feeding the control decoder, with jump LUT and
//                saturating run-time cycle / instruction counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              IW       = DEF_IW,
    parameter int              LUT_AW   = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IW-1:0]     imem_data,
    output logic [PC_W-1:0]   imem_addr,
    output logic [IW-1:0]     mach_code,
    input  logic              stall,
    input  logic              jen,
    input  logic [7:0]        jptr,
    input  logic              br_cond,
    input  logic              done_in,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    fetch_state_t     r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_phase;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_icnt;
    logic [CNT_W-1:0] r_ccnt;

    logic [PC_W-1:0]  w_target;
    logic             w_lut_we;
    logic             w_hold;
    logic             w_retire;
    logic             w_unused_jptr;

    assign w_lut_we      = lut_we && (r_state != RUN);
    assign w_unused_jptr = ^jptr[7:LUT_AW];

    jump_lut #(
        .AW (LUT_AW),
        .DW (PC_W)
    ) u_jump_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_lut_we),
        .i_waddr (lut_waddr),
        .i_wdata (lut_wdata),
        .i_raddr (jptr[LUT_AW-1:0]),
        .o_rdata (w_target)
    );

    // First cycle of a two-cycle instruction: nothing retires, PC stays put.
    assign w_hold   = stall && !r_phase && !done_in;
    assign w_retire = !w_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_phase <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_icnt  <= '0;
            r_ccnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (r_ccnt != '1) begin
                        r_ccnt <= r_ccnt + 1'b1;
                    end
                    if (w_retire && (r_icnt != '1)) begin
                        r_icnt <= r_icnt + 1'b1;
                    end
                    if (done_in) begin
                        r_state <= HALT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_phase <= 1'b0;
                    end else if (w_hold) begin
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_pc    <= (jen && br_cond) ? w_target : r_pc + 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pc    <= RESET_PC;
                        r_phase <= 1'b0;
                        r_icnt  <= '0;
                        r_ccnt  <= '0;
                    end
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign mach_code = (r_state == RUN) ? imem_data : IW'(HALT_INSTR);
    assign busy      = r_busy;
    assign done      = r_done;
    assign instr_cnt = r_icnt;
    assign cycle_cnt = r_ccnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Scoreboard bench for instr_fetch (4-bit counters to reach saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    typedef struct {
        logic [9:0] pc;
        logic [8:0] code;
    } tr_t;

    typedef struct {
        logic [9:0] pc;
        logic [8:0] code;
        logic       busy;
        logic       done;
        logic [3:0] ic;
        logic [3:0] cc;
    } st_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       br_cond = 1'b0;
    logic       lut_we = 1'b0;
    logic [5:0] lut_waddr = '0;
    logic [9:0] lut_wdata = '0;
    logic       snap = 1'b0;

    logic [9:0] imem_addr;
    logic [8:0] mach_code;
    logic [8:0] imem_data;
    logic       stall, jen, done_in, busy, done;
    logic [7:0] jptr;
    logic [3:0] instr_cnt, cycle_cnt;

    logic [8:0] rom       [1024];
    bit         rom_stall [1024];
    bit         rom_jen   [1024];
    logic [7:0] rom_jptr  [1024];

    tr_t q_tr[$];
    st_t q_st[$];
    tr_t m_tr;
    st_t m_st;
    int  total = 0;
    int  bad = 0;

    assign imem_data = rom[imem_addr];
    assign stall     = rom_stall[imem_addr];
    assign jen       = rom_jen[imem_addr];
    assign jptr      = rom_jptr[imem_addr];
    assign done_in   = (imem_data == 9'h0FF);

    instr_fetch #(
        .PC_W     (10),
        .IW       (9),
        .LUT_AW   (6),
        .RESET_PC (10'd0),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .imem_data (imem_data),
        .imem_addr (imem_addr),
        .mach_code (mach_code),
        .stall     (stall),
        .jen       (jen),
        .jptr      (jptr),
        .br_cond   (br_cond),
        .done_in   (done_in),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .busy      (busy),
        .done      (done),
        .instr_cnt (instr_cnt),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one trace entry per RUN cycle, one status entry per snapshot request.
    always @(negedge clk) begin
        if (busy) begin
            if (q_tr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL trace_underflow: got pc %h expected no RUN cycle", imem_addr);
            end else begin
                m_tr = q_tr.pop_front();
                cmp("trace_pc", 32'(imem_addr), 32'(m_tr.pc));
                cmp("trace_code", 32'(mach_code), 32'(m_tr.code));
            end
        end
        if (snap) begin
            if (q_st.size() == 0) begin
                total++;
                bad++;
                $display("FAIL status_underflow: got snapshot expected none");
            end else begin
                m_st = q_st.pop_front();
                cmp("st_pc", 32'(imem_addr), 32'(m_st.pc));
                cmp("st_code", 32'(mach_code), 32'(m_st.code));
                cmp("st_busy", 32'(busy), 32'(m_st.busy));
                cmp("st_done", 32'(done), 32'(m_st.done));
                cmp("st_instr_cnt", 32'(instr_cnt), 32'(m_st.ic));
                cmp("st_cycle_cnt", 32'(cycle_cnt), 32'(m_st.cc));
            end
        end
    end

    task automatic clear_rom();
        for (int a = 0; a < 1024; a++) begin
            rom[a]       = {1'b1, 8'(a)};
            rom_stall[a] = 1'b0;
            rom_jen[a]   = 1'b0;
            rom_jptr[a]  = 8'h00;
        end
    endtask

    task automatic push(input logic [9:0] pc);
        q_tr.push_back('{pc: pc, code: rom[pc]});
    endtask

    task automatic push_seq(input int lo, input int hi);
        for (int p = lo; p <= hi; p++) push(10'(p));
    endtask

    task automatic expect_st(input logic [9:0] pc, input logic [8:0] code, input logic b,
                             input logic d, input logic [3:0] ic, input logic [3:0] cc);
        q_st.push_back('{pc: pc, code: code, busy: b, done: d, ic: ic, cc: cc});
        snap = 1'b1;
        @(negedge clk);
        #1 snap = 1'b0;
    endtask

    // pw >= 0: after pw RUN cycles, rewrite rom[pa] to the halt encoding.
    task automatic run(input bit we_start, input bit we_run, input int pw, input logic [9:0] pa);
        int n;
        @(posedge clk); #1 start = 1'b1; lut_we = we_start;
        @(posedge clk); #1 start = 1'b0; lut_we = we_run;
        @(posedge clk); #1 lut_we = 1'b0;
        if (pw >= 0) begin
            repeat (pw - 1) @(posedge clk);
            #1 rom[pa] = 9'h0FF;
        end
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL run_timeout: got busy=1 after %0d cycles expected halt", n);
        end
    endtask

    initial begin
        clear_rom();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_st(10'h000, 9'h0FF, 1'b0, 1'b0, 4'd0, 4'd0);

        // straight line to halt; LUT[5]=0x20 written in the same IDLE cycle as start
        rom[4] = 9'h0FF;
        lut_waddr = 6'd5;
        lut_wdata = 10'h020;
        push_seq(0, 4);
        run(1'b1, 1'b0, -1, 10'h0);
        expect_st(10'h004, 9'h0FF, 1'b0, 1'b1, 4'd5, 4'd5);

        // two-cycle instruction at PC 2
        clear_rom();
        rom_stall[2] = 1'b1;
        rom[4] = 9'h0FF;
        push(0); push(1); push(2); push(2); push(3); push(4);
        run(1'b0, 1'b0, -1, 10'h0);
        expect_st(10'h004, 9'h0FF, 1'b0, 1'b1, 4'd5, 4'd6);

        // taken branch, with a LUT write attempted during RUN
        clear_rom();
        rom_jen[3]  = 1'b1;
        rom_jptr[3] = 8'hC5;
        rom[5]      = 9'h0FF;
        rom[10'h021] = 9'h0FF;
        br_cond   = 1'b1;
        lut_waddr = 6'd5;
        lut_wdata = 10'h3FF;
        push(0); push(1); push(2); push(3); push(10'h020); push(10'h021);
        run(1'b0, 1'b1, -1, 10'h0);
        expect_st(10'h021, 9'h0FF, 1'b0, 1'b1, 4'd6, 4'd6);

        // branch not taken falls through
        br_cond = 1'b0;
        push_seq(0, 5);
        run(1'b0, 1'b0, -1, 10'h0);
        expect_st(10'h005, 9'h0FF, 1'b0, 1'b1, 4'd6, 4'd6);

        // stalled branch resolves in its second cycle; LUT still holds 0x20
        rom_stall[3] = 1'b1;
        br_cond = 1'b1;
        push(0); push(1); push(2); push(3); push(3); push(10'h020); push(10'h021);
        run(1'b0, 1'b0, -1, 10'h0);
        expect_st(10'h021, 9'h0FF, 1'b0, 1'b1, 4'd6, 4'd7);

        // LUT[7]=0x3FF written alongside start from HALT; PC wraps 0x3FF -> 0
        clear_rom();
        rom_jen[1]  = 1'b1;
        rom_jptr[1] = 8'h07;
        lut_waddr = 6'd7;
        lut_wdata = 10'h3FF;
        push(0); push(1); push(10'h3FF);
        q_tr.push_back('{pc: 10'h000, code: 9'h0FF});
        run(1'b1, 1'b0, 2, 10'h000);
        expect_st(10'h000, 9'h0FF, 1'b0, 1'b1, 4'd4, 4'd4);

        // 20-instruction run saturates 4-bit counters
        clear_rom();
        br_cond = 1'b0;
        rom[19] = 9'h0FF;
        push_seq(0, 19);
        run(1'b0, 1'b0, -1, 10'h0);
        expect_st(10'h013, 9'h0FF, 1'b0, 1'b1, 4'd15, 4'd15);

        // async reset in the second cycle of a stall
        clear_rom();
        rom_stall[2] = 1'b1;
        push(0); push(1); push(2);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        expect_st(10'h000, 9'h0FF, 1'b0, 1'b0, 4'd0, 4'd0);
        rst_n = 1'b1;

        // cleared LUT: taken branch through entry 5 lands on 0
        clear_rom();
        rom_jen[3]  = 1'b1;
        rom_jptr[3] = 8'h05;
        br_cond = 1'b1;
        push(0); push(1); push(2); push(3);
        q_tr.push_back('{pc: 10'h000, code: 9'h0FF});
        run(1'b0, 1'b0, 3, 10'h000);
        expect_st(10'h000, 9'h0FF, 1'b0, 1'b1, 4'd5, 4'd5);

        cmp("trace_leftover", 32'(q_tr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
